// File: rtl/btn_onehot_debounce_if.sv
// rtl/btn_onehot_debounce_if.sv - button input / one-hot press bus between board pins and colour selector
//   btn_raw    : raw button levels (into the debouncer)
//   btn_onehot : one-cycle one-hot press pulse
//   btn_level  : debounced levels
//   press_any  : btn_onehot is nonzero this cycle
//   collision  : two or more debounced rises landed in the same cycle
interface btn_onehot_debounce_if #(
    parameter int N_BTN = 8
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_onehot;
    logic [N_BTN-1:0] btn_level;
    logic             press_any;
    logic             collision;

    modport master (
        output btn_raw,
        input  btn_onehot,
        input  btn_level,
        input  press_any,
        input  collision
    );

    modport slave (
        input  btn_raw,
        output btn_onehot,
        output btn_level,
        output press_any,
        output collision
    );
endinterface

// File: rtl/btn_onehot_debounce.sv
// rtl/btn_onehot_debounce.sv - synchronize, debounce and priority-encode button presses to a one-hot pulse
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : btn_onehot_debounce_if.slave (btn_raw in; btn_onehot, btn_level, press_any, collision out)
module btn_onehot_debounce #(
    parameter int N_BTN           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    btn_onehot_debounce_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_d;
    logic [CNT_W-1:0] cnt [N_BTN];

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] winner;
    logic             multi;

    logic [N_BTN-1:0] onehot_q;
    logic             press_q;
    logic             coll_q;

    // Two-flop synchronizer; raw pins are asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
        end
    end

    // Any cycle where the synchronized level agrees with the accepted level
    // restarts the count, so only an unbroken run of mismatches is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // x & -x isolates the lowest set bit; x & (x-1) is nonzero iff two or more bits are set.
    always_comb begin
        rise   = stable & ~stable_d;
        winner = rise & (~rise + N_BTN'(1));
        multi  = |(rise & (rise - N_BTN'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= '0;
            onehot_q <= '0;
            press_q  <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            stable_d <= stable;
            onehot_q <= winner;
            press_q  <= |rise;
            coll_q   <= multi;
        end
    end

    assign bus.btn_onehot = onehot_q;
    assign bus.btn_level  = stable;
    assign bus.press_any  = press_q;
    assign bus.collision  = coll_q;
endmodule
